// File: rtl/slave_in_port.sv
// slave_in_port: receives LSB-first serial headers and data words from a master and turns
// them into local memory writes or read requests. Define SLAVE_IN_TIMEOUT_EN to enable the inter-word burst timeout.
module slave_in_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 rx_address,
    input  logic                 rx_data,
    input  logic                 rx_burst_number,
    input  logic                 master_valid,
    input  logic                 rd_done,
    output logic                 slave_ready,
    output logic                 mem_we,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_wdata,
    output logic                 rd_req,
    output logic [ADDR_LEN-1:0]  rd_addr,
    output logic [BURST_LEN-1:0] rd_len,
    output logic                 rx_error,
    output logic [2:0]           dbg_state
);

    // Handshake: write_en/read_en start a frame only when sampled in IDLE (slave_ready=1);
    // master_valid high for one cycle announces the next DATA_LEN rx_data bits of a word.
    localparam int HDR_AB  = (ADDR_LEN > BURST_LEN + 1) ? ADDR_LEN : BURST_LEN + 1;
    localparam int HDR_LEN = (HDR_AB > DATA_LEN + 1) ? HDR_AB : DATA_LEN + 1;
    localparam int CW      = $clog2(HDR_LEN + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_HDR_WR = 3'd1,
        RX_HDR_RD = 3'd2,
        WR_BURST  = 3'd3,
        RD_WAIT   = 3'd4
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [ADDR_LEN-1:0]  addr_sr;
    logic [DATA_LEN-1:0]  data_sr;
    logic [BURST_LEN-1:0] burst_sr;
    logic                 burst_flag;
    logic [BURST_LEN-1:0] rem;
    logic                 in_word;

    logic                 in_hdr;
    logic [ADDR_LEN-1:0]  addr_nx;
    logic [DATA_LEN-1:0]  data_nx;
    logic [BURST_LEN-1:0] burst_nx;
    logic [BURST_LEN-1:0] burst_eff;

`ifdef SLAVE_IN_TIMEOUT_EN
    logic [TW-1:0]        tmo_cnt;
`else
    logic [TW-1:0]        timeout_unused;
    assign timeout_unused = TW'(TIMEOUT);
`endif

    assign in_hdr    = (state == RX_HDR_WR) || (state == RX_HDR_RD);
    assign dbg_state = state;

    // Shift registers fill from the MSB so bit 0, sent first, ends up at the LSB.
    always_comb begin
        addr_nx  = addr_sr;
        data_nx  = data_sr;
        burst_nx = burst_sr;
        if (in_hdr && cnt < CW'(ADDR_LEN))
            addr_nx = {rx_address, addr_sr[ADDR_LEN-1:1]};
        if ((in_hdr && cnt >= CW'(1) && cnt <= CW'(DATA_LEN)) || (state == WR_BURST && in_word))
            data_nx = {rx_data, data_sr[DATA_LEN-1:1]};
        if (in_hdr && cnt >= CW'(1) && cnt <= CW'(BURST_LEN))
            burst_nx = {rx_burst_number, burst_sr[BURST_LEN-1:1]};
        burst_eff = (burst_flag && burst_nx != '0) ? burst_nx : BURST_LEN'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_sr     <= '0;
            data_sr     <= '0;
            burst_sr    <= '0;
            burst_flag  <= 1'b0;
            rem         <= '0;
            in_word     <= 1'b0;
            slave_ready <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_len      <= '0;
            rx_error    <= 1'b0;
`ifdef SLAVE_IN_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            mem_we   <= 1'b0;
            rd_req   <= 1'b0;
            rx_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    in_word <= 1'b0;
`ifdef SLAVE_IN_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (write_en)
                        state <= RX_HDR_WR;
                    else if (read_en)
                        state <= RX_HDR_RD;
                end

                RX_HDR_WR, RX_HDR_RD: begin
                    addr_sr  <= addr_nx;
                    data_sr  <= data_nx;
                    burst_sr <= burst_nx;
                    cnt      <= cnt + CW'(1);
                    if (cnt == '0)
                        burst_flag <= rx_burst_number;
                    if (state == RX_HDR_WR && cnt == '0 && !master_valid) begin
                        rx_error <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else if (cnt == HDR_LAST) begin
                        cnt <= '0;
                        if (state == RX_HDR_WR) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_nx;
                            mem_wdata <= data_nx;
                            rem       <= burst_eff - BURST_LEN'(1);
                            state     <= (burst_eff == BURST_LEN'(1)) ? IDLE : WR_BURST;
                        end else begin
                            rd_req      <= 1'b1;
                            rd_addr     <= addr_nx;
                            rd_len      <= burst_eff;
                            slave_ready <= 1'b0;
                            state       <= RD_WAIT;
                        end
                    end
                end

                WR_BURST: begin
                    if (in_word) begin
                        data_sr <= data_nx;
                        if (cnt == DATA_LAST) begin
                            cnt       <= '0;
                            in_word   <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_LEN'(1);
                            mem_wdata <= data_nx;
                            rem       <= rem - BURST_LEN'(1);
                            if (rem == BURST_LEN'(1))
                                state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (master_valid) begin
                        in_word <= 1'b1;
                        cnt     <= '0;
`ifdef SLAVE_IN_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
`ifdef SLAVE_IN_TIMEOUT_EN
                        // Words already written stay written; only the rest of the burst is dropped.
                        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            tmo_cnt  <= '0;
                            rx_error <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
`endif
                    end
                end

                RD_WAIT: begin
                    if (rd_done) begin
                        slave_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    slave_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_in_port.sv
// tb_slave_in_port: randomized bench for slave_in_port; expected memory writes and read
// requests come from a transaction-level model (address + index, burst count rules).
`timescale 1ns/1ps
module tb_slave_in_port;

  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;
  localparam int HL = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write_en = 1'b0, read_en = 1'b0;
  logic rx_address = 1'b0, rx_data = 1'b0, rx_burst_number = 1'b0;
  logic master_valid = 1'b0, rd_done = 1'b0;
  logic slave_ready, mem_we, rd_req, rx_error;
  logic [AL-1:0] mem_addr, rd_addr;
  logic [DL-1:0] mem_wdata;
  logic [BL-1:0] rd_len;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int overlap = 0;

  logic [AL+DL-1:0] exp_q[$];
  logic [AL+DL-1:0] obs_q[$];
  logic [AL+BL-1:0] rd_exp_q[$];
  logic [AL+BL-1:0] rd_obs_q[$];
  logic [DL-1:0] words [16];

  always #5 clk = ~clk;

  slave_in_port dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
    .rx_address(rx_address), .rx_data(rx_data), .rx_burst_number(rx_burst_number),
    .master_valid(master_valid), .rd_done(rd_done), .slave_ready(slave_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_len(rd_len), .rx_error(rx_error), .dbg_state(dbg_state)
  );

  // Monitor: records every write/read request and error pulse seen on the outputs
  always @(negedge clk) begin
    if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
    if (rd_req) rd_obs_q.push_back({rd_addr, rd_len});
    if (rx_error) err_pulses++;
    if (mem_we && rd_req) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic int eff_count(input logic flag, input logic [BL-1:0] bfield);
    if (!flag || bfield == '0) return 1;
    return int'(bfield);
  endfunction

  task automatic fill_words();
    for (int i = 0; i < 16; i++) words[i] = DL'($urandom);
  endtask

  task automatic drain_writes(output int bad, output int nexp, output int nobs);
    nexp = exp_q.size();
    nobs = obs_q.size();
    bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0)
      if (exp_q.pop_front() !== obs_q.pop_front()) bad++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic drain_reads(output int bad, output int nexp, output int nobs);
    nexp = rd_exp_q.size();
    nobs = rd_obs_q.size();
    bad = 0;
    while (rd_exp_q.size() > 0 && rd_obs_q.size() > 0)
      if (rd_exp_q.pop_front() !== rd_obs_q.pop_front()) bad++;
    rd_exp_q.delete();
    rd_obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_header(input bit is_wr, input bit both, input logic [AL-1:0] addr,
                              input logic flag, input logic [BL-1:0] bfield,
                              input logic [DL-1:0] d0, input logic mv0, input int ncyc);
    write_en = is_wr;
    read_en = is_wr ? both : 1'b1;
    @(negedge clk);
    for (int c = 0; c < ncyc; c++) begin
      write_en = 1'($urandom_range(0, 1));
      read_en = 1'($urandom_range(0, 1));
      rx_address = (c < AL) ? addr[c] : 1'($urandom_range(0, 1));
      if (c == 0) rx_burst_number = flag;
      else if (c - 1 < BL) rx_burst_number = bfield[c-1];
      else rx_burst_number = 1'($urandom_range(0, 1));
      if (c >= 1 && c <= DL) rx_data = d0[c-1];
      else rx_data = 1'($urandom_range(0, 1));
      master_valid = (c == 0) ? mv0 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    write_en = 1'b0;
    read_en = 1'b0;
    master_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DL-1:0] w, input int gap);
    master_valid = 1'b0;
    repeat (gap) begin
      rx_data = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    master_valid = 1'b1;
    @(negedge clk);
    master_valid = 1'b0;
    for (int k = 0; k < DL; k++) begin
      rx_data = w[k];
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [AL-1:0] addr, input logic flag, input logic [BL-1:0] bfield,
                          input bit both, input int max_gap);
    int n;
    n = eff_count(flag, bfield);
    for (int i = 0; i < n; i++) exp_q.push_back({addr + AL'(i), words[i]});
    drive_header(1'b1, both, addr, flag, bfield, words[0], 1'b1, HL);
    for (int i = 1; i < n; i++) send_word(words[i], $urandom_range(0, max_gap));
    master_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_read(input logic [AL-1:0] addr, input logic flag, input logic [BL-1:0] bfield,
                         input int wait_cyc);
    rd_exp_q.push_back({addr, BL'(eff_count(flag, bfield))});
    drive_header(1'b0, 1'b0, addr, flag, bfield, DL'($urandom), 1'($urandom_range(0, 1)), HL);
    repeat (wait_cyc) begin
      write_en = 1'($urandom_range(0, 1));
      read_en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    write_en = 1'b0;
    read_en = 1'b0;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (slave_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", slave_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b want 0", rd_req); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error got %b want 0", rx_error); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({rd_addr, rd_len} !== '0) begin errors++; $display("FAIL reset_rd_bus got %h want 0", {rd_addr, rd_len}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (slave_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_release ready=%b we=%b want 1/0", slave_ready, mem_we); end
  endtask

  task automatic test_single_write();
    drive_header(1'b1, 1'b0, 12'h0A5, 1'b0, BL'($urandom), 8'h3C, 1'b1, HL);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we_c13 got %b want 1", mem_we); end
    checks++; if (mem_addr !== 12'h0A5) begin errors++; $display("FAIL single_addr got %h want 0a5", mem_addr); end
    checks++; if (mem_wdata !== 8'h3C) begin errors++; $display("FAIL single_data got %h want 3c", mem_wdata); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_pulse got %b want 0", mem_we); end
    repeat (10) @(negedge clk);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_burst_wrap();
    int bad, ne, no;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_write(12'hFFE, 1'b1, 12'd3, 1'b0, 3);
    drain_writes(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL burst_wrap got %0d writes (%0d bad) want %0d", no, bad, ne); end
  endtask

  task automatic test_read();
    int bad, ne, no;
    rd_exp_q.push_back({12'h123, 12'd5});
    drive_header(1'b0, 1'b0, 12'h123, 1'b1, 12'd5, 8'h00, 1'b0, HL);
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL read_req got %b want 1", rd_req); end
    checks++; if (rd_addr !== 12'h123) begin errors++; $display("FAIL read_addr got %h want 123", rd_addr); end
    checks++; if (rd_len !== 12'd5) begin errors++; $display("FAIL read_len got %0d want 5", rd_len); end
    checks++; if (slave_ready !== 1'b0) begin errors++; $display("FAIL read_ready_low got %b want 0", slave_ready); end
    write_en = 1'b1;
    @(negedge clk);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL read_req_pulse got %b want 0", rd_req); end
    repeat (6) @(negedge clk);
    checks++; if (slave_ready !== 1'b0) begin errors++; $display("FAIL read_wait_ready got %b want 0", slave_ready); end
    write_en = 1'b0;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    checks++; if (slave_ready !== 1'b1) begin errors++; $display("FAIL read_done_ready got %b want 1", slave_ready); end
    repeat (3) @(negedge clk);
    drain_reads(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL read_sb got %0d reqs (%0d bad) want %0d", no, bad, ne); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL read_no_write got %0d writes want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_zero_burst();
    int bad, ne, no;
    fill_words();
    do_write(AL'($urandom), 1'b1, 12'd0, 1'b0, 2);
    drain_writes(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL zero_burst_write got %0d writes (%0d bad) want %0d", no, bad, ne); end
    do_read(AL'($urandom), 1'b1, 12'd0, 2);
    do_read(AL'($urandom), 1'b0, BL'($urandom), 1);
    drain_reads(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL zero_burst_read got %0d reqs (%0d bad) want %0d", no, bad, ne); end
  endtask

  task automatic test_abort();
    int e0;
    e0 = err_pulses;
    drive_header(1'b1, 1'b0, AL'($urandom), 1'b1, 12'd3, 8'hA5, 1'b0, 1);
    checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", rx_error); end
    @(negedge clk);
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL abort_pulse_len got %b want 0", rx_error); end
    repeat (20) @(negedge clk);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_no_write got %0d writes want 0", obs_q.size()); end
    checks++; if (err_pulses - e0 !== 1 || slave_ready !== 1'b1) begin errors++; $display("FAIL abort_idle errs=%0d ready=%b want 1/1", err_pulses - e0, slave_ready); end
    obs_q.delete();
  endtask

  task automatic test_priority();
    int bad, ne, no;
    fill_words();
    do_write(AL'($urandom), 1'b1, 12'd2, 1'b1, 2);
    drain_writes(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL priority_write got %0d writes (%0d bad) want %0d", no, bad, ne); end
    checks++; if (rd_obs_q.size() !== 0) begin errors++; $display("FAIL priority_no_read got %0d reqs want 0", rd_obs_q.size()); end
  endtask

  task automatic test_silent_master();
    int bad, ne, no, e0, waited;
    logic [AL-1:0] a;
    fill_words();
    a = AL'($urandom);
    exp_q.push_back({a, words[0]});
    exp_q.push_back({a + AL'(1), words[1]});
    drive_header(1'b1, 1'b0, a, 1'b1, 12'd4, words[0], 1'b1, HL);
    send_word(words[1], 1);
    e0 = err_pulses;
`ifdef SLAVE_IN_TIMEOUT_EN
    waited = 0;
    while (rx_error !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (waited != 16) begin errors++; $display("FAIL timeout_latency got %0d cycles want 16", waited); end
    repeat (3) @(negedge clk);
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", err_pulses - e0); end
`else
    waited = 40;
    repeat (waited) @(negedge clk);
    checks++; if (err_pulses != e0 || slave_ready !== 1'b1) begin errors++; $display("FAIL silent_wait errs=%0d ready=%b want 0/1", err_pulses - e0, slave_ready); end
    exp_q.push_back({a + AL'(2), words[2]});
    exp_q.push_back({a + AL'(3), words[3]});
    send_word(words[2], 0);
    send_word(words[3], 2);
    repeat (3) @(negedge clk);
`endif
    drain_writes(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL silent_writes got %0d writes (%0d bad) want %0d", no, bad, ne); end
  endtask

  task automatic test_reset_mid_write();
    int bad, ne, no, e0;
    e0 = err_pulses;
    drive_header(1'b1, 1'b0, 12'h5A5, 1'b1, 12'd3, 8'hC3, 1'b1, 6);
    #2 reset = 1'b0;
    #1;
    checks++; if (slave_ready !== 1'b1 || mem_we !== 1'b0 || rd_req !== 1'b0 || rx_error !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl ready=%b we=%b req=%b err=%b want 1/0/0/0", slave_ready, mem_we, rd_req, rx_error);
    end
    checks++; if ({mem_addr, mem_wdata, rd_addr, rd_len} !== '0) begin
      errors++; $display("FAIL midreset_bus got %h want 0", {mem_addr, mem_wdata, rd_addr, rd_len});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (obs_q.size() !== 0 || rd_obs_q.size() !== 0 || err_pulses != e0) begin
      errors++; $display("FAIL midreset_discard writes=%0d reads=%0d errs=%0d want 0/0/0", obs_q.size(), rd_obs_q.size(), err_pulses - e0);
    end
    obs_q.delete();
    rd_obs_q.delete();
    fill_words();
    do_write(AL'($urandom), 1'b1, 12'd2, 1'b0, 1);
    drain_writes(bad, ne, no);
    checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL midreset_next got %0d writes (%0d bad) want %0d", no, bad, ne); end
  endtask

  task automatic test_random();
    int bad, ne, no, kind, e0;
    logic flag;
    e0 = err_pulses;
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      flag = 1'($urandom_range(0, 1));
      if (kind < 2) begin
        fill_words();
        do_write(AL'($urandom), flag, flag ? BL'($urandom_range(0, 6)) : BL'($urandom), 1'($urandom_range(0, 1)), 4);
      end else begin
        do_read(AL'($urandom), flag, BL'($urandom), $urandom_range(0, 5));
      end
      drain_writes(bad, ne, no);
      checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL random_writes t=%0d got %0d (%0d bad) want %0d", t, no, bad, ne); end
      drain_reads(bad, ne, no);
      checks++; if (bad != 0 || no != ne) begin errors++; $display("FAIL random_reads t=%0d got %0d (%0d bad) want %0d", t, no, bad, ne); end
    end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL random_errors got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_exclusive();
    checks++; if (overlap != 0) begin errors++; $display("FAIL we_req_overlap got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read();
    test_zero_burst();
    test_abort();
    test_priority();
    test_silent_master();
    test_reset_mid_write();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
